uart_tx_arbiter: RTL



---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the arbiter state encoding, data width and parity function.
package uart_tx_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACT,
    WAIT_DONE,
    GAP
  } arb_state_t;

  // parity_type 0 = even, 1 = odd
  function automatic logic calc_parity(
    input logic [UART_DATA_W-1:0] data,
    input logic                   parity_type
  );
    return parity_type ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after i_ptr+1.
// Ports: i_req/i_ptr in; o_grant (one-hot), o_idx, o_valid out.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int w_best;
  int w_dist;

  // Rank each request by its distance past the pointer; smallest wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_best  = N;
    w_dist  = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + N - 1 - int'(i_ptr)) % N;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = IW'(i);
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one 11-bit UART serializer among
// NUM_REQ producers; latches byte, computes parity, pulses tx_send.
// Ports: baud_clk, reset (sync, high), req/req_data/parity_type in,
// req_ack/req_done pulses, tx_* to serializer, tx_active/done flags in,
// busy, grant_id, timeout_err out.
// Optional: define UART_TX_TIMEOUT_EN for the WAIT_ACT watchdog.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                         baud_clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*8-1:0]         req_data,
  input  logic                         parity_type,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           req_done,
  output logic                         tx_send,
  output logic [7:0]                   tx_data,
  output logic                         tx_parity_bit,
  output logic                         tx_parity_type,
  input  logic                         tx_active_flag,
  input  logic                         tx_done_flag,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_t             r_state;
  logic [NUM_REQ-1:0]     r_ack;
  logic [NUM_REQ-1:0]     r_done;
  logic                   r_send;
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_par;
  logic                   r_pt;
  logic                   r_busy;
  logic [IW-1:0]          r_gid;
  logic [IW-1:0]          r_ptr;
  logic                   r_err;
  logic [GW-1:0]          r_gap_cnt;

  logic [NUM_REQ-1:0]     w_grant;
  logic [IW-1:0]          w_idx;
  logic                   w_valid;
  logic [UART_DATA_W-1:0] w_sel_data;

`ifdef UART_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES > 0);
`endif

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IW'(i)) w_sel_data = req_data[i*8 +: 8];
    end
  end

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ack     <= '0;
      r_done    <= '0;
      r_send    <= 1'b0;
      r_data    <= '0;
      r_par     <= 1'b0;
      r_pt      <= 1'b0;
      r_busy    <= 1'b0;
      r_gid     <= '0;
      r_ptr     <= IW'(NUM_REQ - 1);
      r_err     <= 1'b0;
      r_gap_cnt <= '0;
`ifdef UART_TX_TIMEOUT_EN
      r_to_cnt  <= '0;
`endif
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      r_send <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_valid && tx_done_flag) begin
            r_data  <= w_sel_data;
            r_pt    <= parity_type;
            r_par   <= calc_parity(w_sel_data, parity_type);
            r_gid   <= w_idx;
            r_ptr   <= w_idx;
            r_ack   <= w_grant;
            r_send  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_state <= WAIT_ACT;
`ifdef UART_TX_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
        end
        WAIT_ACT: begin
          if (tx_active_flag) begin
            r_state <= WAIT_DONE;
          end
`ifdef UART_TX_TIMEOUT_EN
          else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (tx_done_flag) begin
            r_done <= NUM_REQ'(1) << r_gid;
            if (GAP_CYCLES > 0) begin
              r_gap_cnt <= GW'(GAP_CYCLES - 1);
              r_state   <= GAP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ack        = r_ack;
  assign req_done       = r_done;
  assign tx_send        = r_send;
  assign tx_data        = r_data;
  assign tx_parity_bit  = r_par;
  assign tx_parity_type = r_pt;
  assign busy           = r_busy;
  assign grant_id       = r_gid;
  assign timeout_err    = r_err;

endmodule
